muldiv_seq_unit: RTL and testbench



---
 rtl/muldiv_seq_unit_if.sv | 35 +++
 rtl/muldiv_seq_unit.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_seq_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_unit_if.sv
// Handshake/bus bundle for the iterative multiply/divide engine.
//   start       launch request, sampled only while the engine is idle
//   op          000 MUL, 001 UMULL, 010 SMULL, 100 UDIV, 101 SDIV (others illegal)
//   a, b        multiplicand/dividend and multiplier/divisor
//   busy        high while an operation is in flight (including its done cycle)
//   done        one-cycle pulse; results valid from this cycle onward
//   result_lo   product low half, or quotient
//   result_hi   product high half (0 for MUL), or remainder
//   div_by_zero set with done when a divide had b = 0
//   illegal_op  set with done when op was illegal
// master = controller side, slave = engine side.
interface muldiv_seq_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             div_by_zero;
   logic             illegal_op;

   modport master (
      output start, op, a, b,
      input  busy, done, result_lo, result_hi, div_by_zero, illegal_op
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result_lo, result_hi, div_by_zero, illegal_op
   );
endinterface

// File: rtl/muldiv_seq_unit.sv
// Iterative multiply/divide engine retiring BITS_PER_CYCLE result bits per RUN cycle.
// Operands are reduced to magnitudes on accept; sign correction happens in a single FIX
// cycle so the datapath itself is purely unsigned.
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    muldiv_seq_unit_if slave modport (start/op/a/b in; busy/done/results/flags out)
module muldiv_seq_unit #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input logic              clk,
   input logic              reset,
   muldiv_seq_unit_if.slave bus
);
   localparam int unsigned W    = WIDTH;
   localparam int unsigned B    = BITS_PER_CYCLE;
   localparam int unsigned N    = (B == 0) ? 1 : W / B;
   localparam int unsigned CntW = $clog2(N + 1);

   if (((B != 1) && (B != 2) && (B != 4)) || ((W % ((B == 0) ? 1 : B)) != 0))
   begin : g_bad_param
      $error("muldiv_seq_unit: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
   end

   localparam logic [2:0] OpMul   = 3'b000;
   localparam logic [2:0] OpUmull = 3'b001;
   localparam logic [2:0] OpSmull = 3'b010;
   localparam logic [2:0] OpUdiv  = 3'b100;
   localparam logic [2:0] OpSdiv  = 3'b101;

   typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

   state_e          state_q;
   logic [2:0]      op_q;
   logic [W-1:0]    a_q;        // |a|: multiplicand
   logic [W-1:0]    b_q;        // |b|: multiplier (shifted down) or divisor
   logic [2*W-1:0]  acc_q;      // product, or {remainder, dividend -> quotient}
   logic [CntW-1:0] cnt_q;
   logic            res_neg_q;
   logic            rem_neg_q;
   logic            busy_q;
   logic            done_q;
   logic            dz_q;
   logic            il_q;
   logic [W-1:0]    lo_q;
   logic [W-1:0]    hi_q;

   // Accept-time decode of the incoming request
   logic         signed_op, div_op, legal_op, a_neg, b_neg;
   logic [W-1:0] a_mag, b_mag;

   always_comb begin
      signed_op = (bus.op == OpSmull) || (bus.op == OpSdiv);
      div_op    = (bus.op == OpUdiv) || (bus.op == OpSdiv);
      legal_op  = bus.op inside {OpMul, OpUmull, OpSmull, OpUdiv, OpSdiv};
      a_neg     = signed_op & bus.a[W-1];
      b_neg     = signed_op & bus.b[W-1];
      a_mag     = a_neg ? -bus.a : bus.a;
      b_mag     = b_neg ? -bus.b : bus.b;
   end

   // One RUN step for each operation class
   logic [W+B-1:0]   mul_sum;
   logic [2*W+B-1:0] mul_cat;
   logic [2*W-1:0]   acc_mul;
   logic [2*W-1:0]   acc_div;
   logic [W:0]       rem_sh;

   always_comb begin
      // Fresh partial product lands on the top half, then everything slides down B bits.
      // The running sum never exceeds W+B bits since the final product fits in 2W.
      mul_sum = {{B{1'b0}}, acc_q[2*W-1:W]}
              + ({{B{1'b0}}, a_q} * {{W{1'b0}}, b_q[B-1:0]});
      mul_cat = {mul_sum, acc_q[W-1:0]};
      acc_mul = (2*W)'(mul_cat >> B);

      // Restoring division: B quotient bits, MSB first, shifted in at acc[0]
      acc_div = acc_q;
      rem_sh  = '0;
      for (int i = 0; i < int'(B); i++) begin
         rem_sh  = acc_div[2*W-1:W-1];
         acc_div = acc_div << 1;
         if (rem_sh >= {1'b0, b_q}) begin
            acc_div[2*W-1:W] = W'(rem_sh - {1'b0, b_q});
            acc_div[0]       = 1'b1;
         end
      end
   end

   // Sign correction applied in FIX; res_neg_q is only ever set for signed ops
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix, rem_fix;

   always_comb begin
      prod_fix = res_neg_q ? -acc_q : acc_q;
      quo_fix  = res_neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
      rem_fix  = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         il_q      <= 1'b0;
         lo_q      <= '0;
         hi_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  op_q      <= bus.op;
                  a_q       <= a_mag;
                  b_q       <= b_mag;
                  res_neg_q <= a_neg ^ b_neg;
                  rem_neg_q <= a_neg;
                  cnt_q     <= CntW'(N);
                  busy_q    <= 1'b1;
                  dz_q      <= 1'b0;
                  il_q      <= 1'b0;
                  if (!legal_op) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     lo_q    <= '0;
                     hi_q    <= '0;
                     il_q    <= 1'b1;
                  end else if (div_op && (bus.b == '0)) begin
                     // Remainder reports the raw dividend, not its magnitude
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     lo_q    <= '0;
                     hi_q    <= bus.a;
                     dz_q    <= 1'b1;
                  end else begin
                     state_q <= StRun;
                     acc_q   <= div_op ? {{W{1'b0}}, a_mag} : '0;
                  end
               end
            end
            StRun: begin
               if (op_q[2]) begin
                  acc_q <= acc_div;
               end else begin
                  acc_q <= acc_mul;
                  b_q   <= b_q >> B;
               end
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CntW'(1)) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               state_q <= StDone;
               done_q  <= 1'b1;
               if (op_q[2]) begin
                  lo_q <= quo_fix;
                  hi_q <= rem_fix;
               end else begin
                  lo_q <= prod_fix[W-1:0];
                  hi_q <= (op_q == OpMul) ? '0 : prod_fix[2*W-1:W];
               end
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.result_lo   = lo_q;
   assign bus.result_hi   = hi_q;
   assign bus.div_by_zero = dz_q;
   assign bus.illegal_op  = il_q;
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Bench for muldiv_seq_unit: three instances (W32/BPC1, W32/BPC4, W16/BPC2) share one
// stimulus stream. A per-instance monitor compares outputs every cycle against an
// arithmetic model; directed operations also carry hand-computed literals.
module tb_muldiv_seq_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;

   muldiv_seq_unit_if #(.WIDTH(32)) i1 ();
   muldiv_seq_unit_if #(.WIDTH(32)) i4 ();
   muldiv_seq_unit_if #(.WIDTH(16)) i16 ();

   assign i1.start  = start;
   assign i1.op     = op;
   assign i1.a      = a;
   assign i1.b      = b;
   assign i4.start  = start;
   assign i4.op     = op;
   assign i4.a      = a;
   assign i4.b      = b;
   assign i16.start = start;
   assign i16.op    = op;
   assign i16.a     = a[15:0];
   assign i16.b     = b[15:0];

   muldiv_seq_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .reset(reset), .bus(i1)
   );
   muldiv_seq_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .reset(reset), .bus(i4)
   );
   muldiv_seq_unit #(.WIDTH(16), .BITS_PER_CYCLE(2)) u_dut16 (
      .clk(clk), .reset(reset), .bus(i16)
   );

   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
      logic        il;
   } res_t;

   int   errors = 0;
   int   checks = 0;
   res_t exp_q1[$];
   res_t exp_q4[$];
   res_t exp_q16[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic cmp_out(input string tag, input res_t e, input logic [31:0] lo, hi,
                          input logic dz, il);
      chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
      chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
      chk({tag, "_dz"}, 64'(dz), 64'(e.dz));
      chk({tag, "_il"}, 64'(il), 64'(e.il));
   endtask

   // Reference arithmetic at operand width w
   function automatic res_t model(input logic [2:0] mop, input logic [31:0] ma, mb, input int w);
      longint unsigned mask, ua, ub, p;
      longint          sa, sb;
      res_t            r;
      r    = '0;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'h0, ma} & mask;
      ub   = {32'h0, mb} & mask;
      sa   = (((ua >> (w - 1)) & 64'd1) != 0) ? $signed(ua) - $signed(mask + 64'd1) : $signed(ua);
      sb   = (((ub >> (w - 1)) & 64'd1) != 0) ? $signed(ub) - $signed(mask + 64'd1) : $signed(ub);
      case (mop)
         3'b000: begin p = ua * ub; r.lo = 32'(p & mask); end
         3'b001: begin p = ua * ub; r.lo = 32'(p & mask); r.hi = 32'((p >> w) & mask); end
         3'b010: begin
            p    = $unsigned(sa * sb);
            r.lo = 32'(p & mask);
            r.hi = 32'((p >> w) & mask);
         end
         3'b100, 3'b101: begin
            if (ub == 0) begin
               r.hi = 32'(ua);
               r.dz = 1'b1;
            end else if (mop == 3'b100) begin
               r.lo = 32'(ua / ub);
               r.hi = 32'(ua % ub);
            end else begin
               r.lo = 32'($unsigned(sa / sb) & mask);
               r.hi = 32'($unsigned(sa % sb) & mask);
            end
         end
         default: r.il = 1'b1;
      endcase
      return r;
   endfunction

   // Per-instance monitors: done pops the model result; otherwise outputs must hold
   res_t held1 = '0, held4 = '0, held16 = '0;

   always @(negedge clk) begin
      if (!reset) begin
         held1 = '0;
         exp_q1.delete();
      end else if (i1.done) begin
         chk("d1_done_expected", 64'(exp_q1.size() != 0), 64'(1));
         if (exp_q1.size() != 0) held1 = exp_q1.pop_front();
         cmp_out("d1_done", held1, i1.result_lo, i1.result_hi, i1.div_by_zero, i1.illegal_op);
      end else if (i1.busy) begin
         cmp_out("d1_busy", res_t'({held1.lo, held1.hi, 2'b00}), i1.result_lo, i1.result_hi,
                 i1.div_by_zero, i1.illegal_op);
      end else begin
         cmp_out("d1_idle", held1, i1.result_lo, i1.result_hi, i1.div_by_zero, i1.illegal_op);
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         held4 = '0;
         exp_q4.delete();
      end else if (i4.done) begin
         chk("d4_done_expected", 64'(exp_q4.size() != 0), 64'(1));
         if (exp_q4.size() != 0) held4 = exp_q4.pop_front();
         cmp_out("d4_done", held4, i4.result_lo, i4.result_hi, i4.div_by_zero, i4.illegal_op);
      end else if (i4.busy) begin
         cmp_out("d4_busy", res_t'({held4.lo, held4.hi, 2'b00}), i4.result_lo, i4.result_hi,
                 i4.div_by_zero, i4.illegal_op);
      end else begin
         cmp_out("d4_idle", held4, i4.result_lo, i4.result_hi, i4.div_by_zero, i4.illegal_op);
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         held16 = '0;
         exp_q16.delete();
      end else if (i16.done) begin
         chk("d16_done_expected", 64'(exp_q16.size() != 0), 64'(1));
         if (exp_q16.size() != 0) held16 = exp_q16.pop_front();
         cmp_out("d16_done", held16, {16'h0, i16.result_lo}, {16'h0, i16.result_hi},
                 i16.div_by_zero, i16.illegal_op);
      end else if (i16.busy) begin
         cmp_out("d16_busy", res_t'({held16.lo, held16.hi, 2'b00}), {16'h0, i16.result_lo},
                 {16'h0, i16.result_hi}, i16.div_by_zero, i16.illegal_op);
      end else begin
         cmp_out("d16_idle", held16, {16'h0, i16.result_lo}, {16'h0, i16.result_hi},
                 i16.div_by_zero, i16.illegal_op);
      end
   end

   // Launch one operation on all three instances and wait (bounded) for every done
   task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] xa, xb,
                        input logic lit, input logic [31:0] elo, ehi, input logic edz, eil);
      res_t        m1, m16;
      int          lat1, lat4, lat16, el1, el4, el16, edges, busy1;
      logic [31:0] rlo, rhi;
      logic        rdz, ril, bad, dv;
      m1    = model(o, xa, xb, 32);
      m16   = model(o, xa, xb, 16);
      bad   = !(o inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      dv    = (o == 3'b100) || (o == 3'b101);
      el1   = (bad || (dv && xb == 32'h0)) ? 1 : 34;
      el4   = (bad || (dv && xb == 32'h0)) ? 1 : 10;
      el16  = (bad || (dv && xb[15:0] == 16'h0)) ? 1 : 10;
      lat1  = 0;
      lat4  = 0;
      lat16 = 0;
      busy1 = 0;
      rlo   = '0;
      rhi   = '0;
      rdz   = 1'b0;
      ril   = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      op    = o;
      a     = xa;
      b     = xb;
      exp_q1.push_back(m1);
      exp_q4.push_back(m1);
      exp_q16.push_back(m16);
      @(posedge clk); #1;
      // Accept edge is edge 1; inputs are free to change now
      start = 1'b0;
      op    = 3'($urandom);
      a     = $urandom;
      b     = $urandom;
      edges = 1;
      for (int e = 0; e < 100; e++) begin
         @(negedge clk);
         if (i1.busy) busy1++;
         if (i1.done && lat1 == 0) begin
            lat1 = edges;
            rlo  = i1.result_lo;
            rhi  = i1.result_hi;
            rdz  = i1.div_by_zero;
            ril  = i1.illegal_op;
         end
         if (i4.done && lat4 == 0) lat4 = edges;
         if (i16.done && lat16 == 0) lat16 = edges;
         if (lat1 != 0 && lat4 != 0 && lat16 != 0) break;
         @(posedge clk);
         edges++;
      end
      chk({tag, "_lat_w32b1"}, 64'(lat1), 64'(el1));
      chk({tag, "_lat_w32b4"}, 64'(lat4), 64'(el4));
      chk({tag, "_lat_w16b2"}, 64'(lat16), 64'(el16));
      chk({tag, "_busy_cycles"}, 64'(busy1), 64'(el1));
      if (lit) begin
         cmp_out({tag, "_lit_dut"}, res_t'({elo, ehi, edz, eil}), rlo, rhi, rdz, ril);
         cmp_out({tag, "_lit_model"}, res_t'({elo, ehi, edz, eil}), m1.lo, m1.hi, m1.dz, m1.il);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 64'(i1.done), 64'(0));
      chk({tag, "_idle_after"}, 64'(i1.busy), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          seen_done;
      logic [2:0]  ops [5];
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ops   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      reset = 1'b0;
      start = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp_out("rst_d1", res_t'(66'h0), i1.result_lo, i1.result_hi, i1.div_by_zero,
              i1.illegal_op);
      chk("rst_d1_busy", 64'(i1.busy), 64'(0));
      chk("rst_d1_done", 64'(i1.done), 64'(0));
      chk("rst_d4_busy", 64'(i4.busy), 64'(0));
      chk("rst_d16_busy", 64'(i16.busy), 64'(0));
      @(posedge clk); #1;
      reset = 1'b1;

      do_op("umull_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 32'hFFFFFFFE,
            1'b0, 1'b0);
      do_op("smull_neg", 3'b010, 32'hFFFFFFFD, 32'h7, 1'b1, 32'hFFFFFFEB, 32'hFFFFFFFF,
            1'b0, 1'b0);
      do_op("mul_neg", 3'b000, 32'hFFFFFFFD, 32'h7, 1'b1, 32'hFFFFFFEB, 32'h0, 1'b0, 1'b0);
      do_op("udiv", 3'b100, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0);
      do_op("sdiv_neg", 3'b101, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF,
            1'b0, 1'b0);
      do_op("sdiv_wrap", 3'b101, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0,
            1'b0, 1'b0);
      do_op("udiv_zero", 3'b100, 32'd5, 32'd0, 1'b1, 32'd0, 32'd5, 1'b1, 1'b0);
      do_op("illegal", 3'b111, 32'h1234, 32'h5678, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1);
      do_op("umull_b4", 3'b001, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h242D2080, 32'h0B00EA4E,
            1'b0, 1'b0);

      // Long operation: ignored start mid-RUN, then reset mid-RUN
      @(posedge clk); #1;
      start = 1'b1;
      op    = 3'b001;
      a     = 32'hDEADBEEF;
      b     = 32'h01234567;
      exp_q1.push_back(model(3'b001, a, b, 32));
      exp_q4.push_back(model(3'b001, a, b, 32));
      exp_q16.push_back(model(3'b001, a, b, 16));
      @(posedge clk); #1;
      start     = 1'b0;
      seen_done = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (i1.done) seen_done++;
         @(posedge clk); #1;
         if (c == 4) begin
            start = 1'b1;
            op    = 3'b100;
            a     = 32'd77;
            b     = 32'd3;
         end
         if (c == 5) start = 1'b0;
         if (c == 9) reset = 1'b0;
      end
      @(negedge clk);
      chk("abort_no_done", 64'(seen_done), 64'(0));
      chk("abort_d1_busy", 64'(i1.busy), 64'(0));
      chk("abort_d1_done", 64'(i1.done), 64'(0));
      cmp_out("abort_d1", res_t'(66'h0), i1.result_lo, i1.result_hi, i1.div_by_zero,
              i1.illegal_op);
      chk("abort_d4_lo", 64'(i4.result_lo), 64'(0));
      chk("abort_d16_lo", 64'(i16.result_lo), 64'(0));
      @(posedge clk); #1;
      reset = 1'b1;

      do_op("udiv_after_rst", 3'b100, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         ro = ops[$urandom_range(0, 4)];
         ra = $urandom;
         rb = $urandom;
         if (i % 3 == 0) rb = 32'($urandom_range(1, 300));
         if (i % 4 == 1) rb = -rb;
         if (i % 7 == 6) rb = 32'h0;
         if (i % 5 == 2) rb[15:0] = 16'h0;
         do_op("rand", ro, ra, rb, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
